// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch unit.
package if_pkg;

    localparam int XLEN    = 32;
    localparam int PC_STEP = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DROP = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: one outstanding imem request, redirect handling,
// and a combinational response hand-off to the IF/ID register.
module if_fetch_unit
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            stall,
    input  logic            if_id_valid,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    output logic            imem_resp_ready,
    input  logic [XLEN-1:0] imem_resp_data,
    output logic            imem_resp_fire,
    output logic [XLEN-1:0] pc_current
);

    fetch_state_t    r_state;
    fetch_state_t    w_nextState;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_nextPc;
    logic [XLEN-1:0] w_redirectPc;
    logic            w_accept;
    logic            w_unusedData;

    assign w_accept     = !if_id_valid || (if_id_valid && !stall);
    assign w_redirectPc = {redirect_pc[XLEN-1:2], 2'b00};
    assign w_unusedData = ^imem_resp_data;

    assign imem_req_addr = r_pc;
    assign pc_current    = r_pc;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_nextState;
            r_pc    <= w_nextPc;
        end
    end

    // Outputs are forced low while reset is held, even before the state register clears.
    always_comb begin
        w_nextState     = r_state;
        w_nextPc        = r_pc;
        imem_req_valid  = 1'b0;
        imem_resp_ready = 1'b0;
        imem_resp_fire  = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_nextState = S_REQ;
            end

            S_REQ: begin
                imem_req_valid = reset_n && !redirect_valid;
                if (redirect_valid) begin
                    w_nextPc = w_redirectPc;
                end else if (imem_req_ready) begin
                    w_nextState = S_WAIT;
                end
            end

            S_WAIT: begin
                imem_resp_ready = reset_n && (redirect_valid || w_accept);
                imem_resp_fire  = reset_n && imem_resp_valid && w_accept && !redirect_valid;
                if (redirect_valid) begin
                    w_nextPc    = w_redirectPc;
                    w_nextState = imem_resp_valid ? S_REQ : S_DROP;
                end else if (imem_resp_valid && w_accept) begin
                    w_nextPc    = r_pc + XLEN'(PC_STEP);
                    w_nextState = S_REQ;
                end
            end

            S_DROP: begin
                imem_resp_ready = reset_n;
                if (redirect_valid) begin
                    w_nextPc = w_redirectPc;
                end
                // The stale response is consumed here, so it must win over a concurrent redirect.
                if (imem_resp_valid) begin
                    w_nextState = S_REQ;
                end
            end

            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed vector table, hand-written
// corner sequences, and randomized traffic against a transaction-level model.
module tb_if_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk;
    logic        reset_n;
    logic        stall;
    logic        if_id_valid;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic        imem_resp_ready;
    logic [31:0] imem_resp_data;
    logic        imem_resp_fire;
    logic [31:0] pc_current;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        rstN;
        logic        stl;
        logic        ifv;
        logic        redir;
        logic [31:0] rpc;
        logic        reqRdy;
        logic        respV;
        logic        expReqV;
        logic [31:0] expAddr;
        logic        expRespRdy;
        logic        expFire;
        logic [31:0] expPc;
    } vec_t;

    vec_t vecs[$];

    if_fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .stall           (stall),
        .if_id_valid     (if_id_valid),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_ready (imem_resp_ready),
        .imem_resp_data  (imem_resp_data),
        .imem_resp_fire  (imem_resp_fire),
        .pc_current      (pc_current)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        reset_n         = v.rstN;
        stall           = v.stl;
        if_id_valid     = v.ifv;
        redirect_valid  = v.redir;
        redirect_pc     = v.rpc;
        imem_req_ready  = v.reqRdy;
        imem_resp_valid = v.respV;
        imem_resp_data  = $urandom;
    endtask

    task automatic checkOutput(input string tag, input vec_t v);
        checkVal({tag, ".req_valid"}, 32'(imem_req_valid), 32'(v.expReqV));
        if (v.expReqV)
            checkVal({tag, ".req_addr"}, imem_req_addr, v.expAddr);
        checkVal({tag, ".resp_ready"}, 32'(imem_resp_ready), 32'(v.expRespRdy));
        checkVal({tag, ".fire"}, 32'(imem_resp_fire), 32'(v.expFire));
        if (v.expFire)
            checkVal({tag, ".pc_current"}, pc_current, v.expPc);
    endtask

    // Drive one cycle at the falling edge, check mid-cycle, then step past the rising edge.
    task automatic runVec(input string tag, input vec_t v);
        applyStimulus(v);
        #2;
        checkOutput(tag, v);
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic vec_t mk(input logic rstN, input logic stl, input logic ifv,
                                input logic redir, input logic [31:0] rpc,
                                input logic reqRdy, input logic respV,
                                input logic expReqV, input logic [31:0] expAddr,
                                input logic expRespRdy, input logic expFire,
                                input logic [31:0] expPc);
        vec_t v;
        v.rstN = rstN; v.stl = stl; v.ifv = ifv; v.redir = redir; v.rpc = rpc;
        v.reqRdy = reqRdy; v.respV = respV; v.expReqV = expReqV; v.expAddr = expAddr;
        v.expRespRdy = expRespRdy; v.expFire = expFire; v.expPc = expPc;
        return v;
    endfunction

    // Reference model state: whether a request is in flight, whether its answer is stale.
    bit          mWarm;
    bit          mBusy;
    bit          mStale;
    logic [31:0] mPc;

    function automatic vec_t modelExpect(input vec_t v);
        vec_t e = v;
        bit acc = !(v.ifv && v.stl);
        e.expReqV    = v.rstN && mWarm && !mBusy && !v.redir;
        e.expAddr    = mPc;
        e.expRespRdy = v.rstN && mBusy && (mStale || v.redir || acc);
        e.expFire    = v.rstN && mBusy && !mStale && !v.redir && v.respV && acc;
        e.expPc      = mPc;
        return e;
    endfunction

    task automatic modelUpdate(input vec_t v);
        bit acc = !(v.ifv && v.stl);
        if (!v.rstN) begin
            mWarm = 0; mBusy = 0; mStale = 0; mPc = RST_PC;
        end else if (!mWarm) begin
            mWarm = 1;
        end else if (!mBusy) begin
            if (v.redir) mPc = v.rpc & ~32'd3;
            else if (v.reqRdy) mBusy = 1;
        end else if (v.redir) begin
            mPc = v.rpc & ~32'd3;
            if (v.respV) begin mBusy = 0; mStale = 0; end
            else mStale = 1;
        end else if (mStale) begin
            if (v.respV) begin mBusy = 0; mStale = 0; end
        end else if (v.respV && acc) begin
            mPc = mPc + 32'd4;
            mBusy = 0;
        end
    endtask

    initial begin
        vec_t v;
        reset_n = 0; stall = 0; if_id_valid = 0; redirect_valid = 0; redirect_pc = '0;
        imem_req_ready = 0; imem_resp_valid = 0; imem_resp_data = '0;

        //          rst stl ifv rdr rpc           rdy rsp  reqV addr          rRdy fire pc
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 0,   0, 32'h0,         0, 0, 32'h0));
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,        0, 0,   0, 32'h0,         0, 0, 32'h0));
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,        1, 0,   1, 32'h0,         0, 0, 32'h0));
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,        0, 1,   0, 32'h0,         1, 1, 32'h0));
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,        0, 0,   1, 32'h4,         0, 0, 32'h0));
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,        0, 0,   1, 32'h4,         0, 0, 32'h0));
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,        0, 0,   1, 32'h4,         0, 0, 32'h0));
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,        1, 0,   1, 32'h4,         0, 0, 32'h0));
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,        1, 0,   0, 32'h0,         1, 0, 32'h0));
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,        0, 1,   0, 32'h0,         1, 1, 32'h4));
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,        1, 0,   1, 32'h8,         0, 0, 32'h0));
        vecs.push_back(mk(1, 1, 1, 0, 32'h0,        0, 1,   0, 32'h0,         0, 0, 32'h0));
        vecs.push_back(mk(1, 1, 1, 0, 32'h0,        0, 1,   0, 32'h0,         0, 0, 32'h0));
        vecs.push_back(mk(1, 0, 1, 0, 32'h0,        0, 1,   0, 32'h0,         1, 1, 32'h8));
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,        1, 0,   1, 32'hC,         0, 0, 32'h0));
        vecs.push_back(mk(1, 0, 0, 1, 32'h103,      0, 0,   0, 32'h0,         1, 0, 32'h0));
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,        0, 0,   0, 32'h0,         1, 0, 32'h0));
        vecs.push_back(mk(1, 1, 1, 0, 32'h0,        0, 1,   0, 32'h0,         1, 0, 32'h0));
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,        1, 0,   1, 32'h100,       0, 0, 32'h0));
        vecs.push_back(mk(1, 0, 0, 1, 32'h200,      0, 1,   0, 32'h0,         1, 0, 32'h0));
        vecs.push_back(mk(1, 0, 0, 1, 32'h303,      1, 0,   0, 32'h0,         0, 0, 32'h0));
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,        1, 0,   1, 32'h300,       0, 0, 32'h0));
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,        0, 1,   0, 32'h0,         1, 1, 32'h300));

        #1;
        for (int i = 0; i < vecs.size(); i++)
            runVec($sformatf("vec%0d", i), vecs[i]);

        // Sequential wrap from the top of the address space.
        runVec("wrap_redir", mk(1, 0, 0, 1, 32'hFFFF_FFFE, 1, 0, 0, 32'h0, 0, 0, 32'h0));
        runVec("wrap_req",   mk(1, 0, 0, 0, 32'h0, 1, 0, 1, 32'hFFFF_FFFC, 0, 0, 32'h0));
        runVec("wrap_resp",  mk(1, 0, 0, 0, 32'h0, 0, 1, 0, 32'h0, 1, 1, 32'hFFFF_FFFC));
        runVec("wrap_next",  mk(1, 0, 0, 0, 32'h0, 1, 0, 1, 32'h0, 0, 0, 32'h0));
        runVec("wrap_fire",  mk(1, 0, 0, 0, 32'h0, 0, 1, 0, 32'h0, 1, 1, 32'h0));

        // Reset while waiting: the late response must not be delivered.
        runVec("rst_req",    mk(1, 0, 0, 0, 32'h0, 1, 0, 1, 32'h4, 0, 0, 32'h0));
        runVec("rst_assert", mk(0, 0, 0, 0, 32'h0, 1, 1, 0, 32'h0, 0, 0, 32'h0));
        runVec("rst_late",   mk(1, 0, 0, 0, 32'h0, 1, 1, 0, 32'h0, 0, 0, 32'h0));
        runVec("rst_refetch",mk(1, 0, 0, 0, 32'h0, 1, 1, 1, RST_PC, 0, 0, 32'h0));
        runVec("rst_fire",   mk(1, 0, 0, 0, 32'h0, 0, 1, 0, 32'h0, 1, 1, RST_PC));

        // Randomized traffic, model starts from a reset cycle.
        for (int c = 0; c < 3000; c++) begin
            v.rstN   = (c == 0) ? 1'b0 : ($urandom_range(0, 99) != 0);
            v.stl    = ($urandom_range(0, 3) == 0);
            v.ifv    = $urandom_range(0, 1);
            v.redir  = ($urandom_range(0, 9) == 0);
            v.rpc    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            v.reqRdy = ($urandom_range(0, 2) != 0);
            v.respV  = ($urandom_range(0, 2) != 0);
            v = modelExpect(v);
            applyStimulus(v);
            #2;
            checkOutput("rand", v);
            @(posedge clk);
            modelUpdate(v);
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have ports (name direction width meaning):
- clk  in  1  sole clock; all state on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- stall  in  1  decode stall.
- if_id_valid  in  1  IF/ID register holds an instruction.
- redirect_valid  in  1  PC redirect request (branch/jump/flush).
- redirect_pc  in  32  redirect target.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  32  fetch address.
- imem_resp_valid  in  1  memory response valid.
- imem_resp_ready  out  1  unit accepts response.
- imem_resp_data  in  32  instruction word; passed through, not registered.
- imem_resp_fire  out  1  response delivered to IF/ID this cycle.
- pc_current  out  32  PC of the instruction delivered on imem_resp_fire.

Function
REQ-003 SHALL compute accept = !if_id_valid || (if_id_valid && !stall).
REQ-004 SHALL implement FSM states S_IDLE, S_REQ, S_WAIT, S_DROP, with at most one outstanding request.
REQ-005 S_IDLE SHALL drive no request and go to S_REQ on the next cycle.
REQ-006 S_REQ SHALL drive imem_req_valid = !redirect_valid and imem_req_addr = pc.
REQ-007 In S_REQ, a handshake (req_valid && req_ready) SHALL move the FSM to S_WAIT, with pc unchanged.
REQ-008 In S_REQ, redirect_valid SHALL load pc <= {redirect_pc[31:2],2'b00} and keep the FSM in S_REQ; no request issues that cycle.
REQ-009 In S_WAIT, imem_resp_ready SHALL equal accept.
REQ-010 In S_WAIT, resp_valid && accept && !redirect_valid SHALL assert imem_resp_fire for 1 cycle, then load pc <= pc+4 and go to S_REQ.
REQ-011 In S_WAIT, redirect_valid SHALL force imem_resp_ready=1, imem_resp_fire=0, and load the redirect pc.
- If resp_valid is high the same cycle, the response is discarded and the FSM goes to S_REQ.
- Otherwise the FSM goes to S_DROP.
REQ-012 In S_DROP, imem_resp_ready SHALL be 1 and imem_resp_fire SHALL be 0.
- resp_valid moves the FSM to S_REQ.
- A redirect in S_DROP reloads pc and keeps the FSM in S_DROP.
REQ-013 In S_WAIT, resp_valid && !accept SHALL leave imem_resp_ready=0 with state and pc held; delivery follows the cycle accept rises.
REQ-014 pc_current SHALL equal pc, the address of the outstanding request; it is meaningful only while imem_resp_fire=1.
REQ-015 imem_resp_fire SHALL equal imem_resp_valid && imem_resp_ready && (state==S_WAIT) && !redirect_valid.
REQ-016 pc+4 SHALL be 32-bit modular (32'hFFFF_FFFC -> 32'h0000_0000), and redirect_pc[1:0] SHALL be ignored.
REQ-017 Best-case throughput SHALL be one instruction per 2 cycles (REQ->WAIT->REQ) with a zero-wait memory.

Reset
REQ-018 While reset_n=0 at a clock edge, the unit SHALL set state=S_IDLE and pc=RESET_PC.
REQ-019 During reset, imem_req_valid, imem_resp_ready and imem_resp_fire SHALL be 0.
REQ-020 Reset asserted mid-transaction (S_WAIT/S_DROP) SHALL abandon the outstanding request; any response arriving after reset is not delivered.

Structure
REQ-021 Package if_pkg SHALL hold the fetch_state_t enum (S_IDLE, S_REQ, S_WAIT, S_DROP), the XLEN=32 constant and the PC_STEP=4 constant.
REQ-022 The block SHALL be a single module with no sub-modules: FSM and PC register are flat, and outputs are combinational from state and inputs.

Verification
REQ-023 Reset with RESET_PC=0, zero-wait memory, no stall -> requests at 0x0, 0x4, 0x8; imem_resp_fire every 2nd cycle with pc_current 0x0, 0x4, 0x8.
REQ-024 imem_req_ready low 3 cycles in S_REQ -> imem_req_addr held at 0x4; request accepted on cycle 4; no duplicate request issued.
REQ-025 if_id_valid=1 and stall=1 while a response is pending for 0x8 -> imem_resp_ready=0, no fire; stall drops -> fire with pc_current=0x8.
REQ-026 Redirect to 0x103 in S_WAIT one cycle before the response -> FSM enters S_DROP; the stale response is dropped without fire; next request addr = 0x100.
REQ-027 Redirect in the same cycle as the response -> the response is discarded, fire=0; the next request is issued to the redirect target.
REQ-028 pc=0xFFFF_FFFC delivered -> next request addr = 0x0000_0000; reset_n=0 during S_WAIT -> next request is to RESET_PC and the late response causes no fire.
